// File: rtl/shift_seq_32.sv
// Multi-cycle logical shifter: one internal shift-by-1 for odd amounts, then
// iterates an external combinational shift-by-2 stage via SH_IN/SH_OUT.
module shift_seq_32 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        DIR,
    input  logic [4:0]  AMT,
    input  logic [31:0] DIN,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] DOUT,
    output logic [31:0] SH_IN,
    input  logic [31:0] SH_OUT,
    output logic        L_SHIFT,
    output logic        NO_SHIFT,
    output logic        R_SHIFT,
    output logic        LEFT_NOT,
    output logic        OLD_NOT,
    output logic        RIGHT_NOT
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ODD,
        S_PASS,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] reg_q, reg_nxt;
    logic [3:0]  cnt_q, cnt_nxt;
    logic        dir_q, dir_nxt;
    logic        sel_l_nxt, sel_r_nxt, sel_n_nxt;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        reg_nxt   = reg_q;
        cnt_nxt   = cnt_q;
        dir_nxt   = dir_q;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (START) begin
                    reg_nxt = DIN;
                    cnt_nxt = AMT[4:1];
                    dir_nxt = DIR;
                    if (AMT == 5'd0)
                        state_nxt = S_DONE;
                    else if (AMT[0])
                        state_nxt = S_ODD;
                    else
                        state_nxt = S_PASS;
                end
            end
            S_ODD: begin
                reg_nxt   = dir_q ? {1'b0, reg_q[31:1]} : {reg_q[30:0], 1'b0};
                state_nxt = (cnt_q != 4'd0) ? S_PASS : S_DONE;
            end
            S_PASS: begin
                reg_nxt   = SH_OUT;
                cnt_nxt   = cnt_q - 4'd1;
                state_nxt = (cnt_q == 4'd1) ? S_DONE : S_PASS;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Selects are decoded from next state/direction so the flops present
    // the right selection during the PASS cycle itself, glitch-free.
    always_comb begin
        sel_l_nxt = (state_nxt == S_PASS) && !dir_nxt;
        sel_r_nxt = (state_nxt == S_PASS) && dir_nxt;
        sel_n_nxt = (state_nxt != S_PASS);
    end

    // NOTE: clocked blocks use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            reg_q     <= 32'd0;
            cnt_q     <= 4'd0;
            dir_q     <= 1'b0;
            L_SHIFT   <= 1'b0;
            NO_SHIFT  <= 1'b1;
            R_SHIFT   <= 1'b0;
            LEFT_NOT  <= 1'b1;
            OLD_NOT   <= 1'b0;
            RIGHT_NOT <= 1'b1;
        end else begin
            reg_q     <= reg_nxt;
            cnt_q     <= cnt_nxt;
            dir_q     <= dir_nxt;
            L_SHIFT   <= sel_l_nxt;
            NO_SHIFT  <= sel_n_nxt;
            R_SHIFT   <= sel_r_nxt;
            LEFT_NOT  <= !sel_l_nxt;
            OLD_NOT   <= !sel_n_nxt;
            RIGHT_NOT <= !sel_r_nxt;
        end
    end

    assign BUSY  = (state == S_ODD) || (state == S_PASS);
    assign DONE  = (state == S_DONE);
    assign DOUT  = reg_q;
    assign SH_IN = reg_q;

endmodule

// File: tb/tb_shift_seq_32.sv
// Self-checking bench for shift_seq_32 with a behavioural shift-by-2 stage,
// directed vector table, multi-cycle corner sequences and random ops.
module tb_shift_seq_32;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        DIR;
    logic [4:0]  AMT;
    logic [31:0] DIN;
    logic        BUSY;
    logic        DONE;
    logic [31:0] DOUT;
    logic [31:0] SH_IN;
    logic [31:0] SH_OUT;
    logic        L_SHIFT, NO_SHIFT, R_SHIFT;
    logic        LEFT_NOT, OLD_NOT, RIGHT_NOT;

    int errors = 0;
    int checks = 0;
    bit inv_en = 0;

    shift_seq_32 dut (
        .CLK(CLK), .RST(RST), .START(START), .DIR(DIR), .AMT(AMT), .DIN(DIN),
        .BUSY(BUSY), .DONE(DONE), .DOUT(DOUT), .SH_IN(SH_IN), .SH_OUT(SH_OUT),
        .L_SHIFT(L_SHIFT), .NO_SHIFT(NO_SHIFT), .R_SHIFT(R_SHIFT),
        .LEFT_NOT(LEFT_NOT), .OLD_NOT(OLD_NOT), .RIGHT_NOT(RIGHT_NOT)
    );

    // External shift-by-2 stage
    always_comb begin
        SH_OUT = SH_IN;
        if (L_SHIFT)
            SH_OUT = {SH_IN[29:0], 2'b00};
        else if (R_SHIFT)
            SH_OUT = {2'b00, SH_IN[31:2]};
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (inv_en) begin
            check("sel_onehot", int'(L_SHIFT) + int'(NO_SHIFT) + int'(R_SHIFT), 1);
            check("left_not",  {31'b0, LEFT_NOT},  {31'b0, ~L_SHIFT});
            check("old_not",   {31'b0, OLD_NOT},   {31'b0, ~NO_SHIFT});
            check("right_not", {31'b0, RIGHT_NOT}, {31'b0, ~R_SHIFT});
        end
    end

    task automatic check_reset_vals();
        check("rst_busy",      {31'b0, BUSY},      0);
        check("rst_done",      {31'b0, DONE},      0);
        check("rst_dout",      DOUT,               0);
        check("rst_sh_in",     SH_IN,              0);
        check("rst_l_shift",   {31'b0, L_SHIFT},   0);
        check("rst_no_shift",  {31'b0, NO_SHIFT},  1);
        check("rst_r_shift",   {31'b0, R_SHIFT},   0);
        check("rst_left_not",  {31'b0, LEFT_NOT},  1);
        check("rst_old_not",   {31'b0, OLD_NOT},   0);
        check("rst_right_not", {31'b0, RIGHT_NOT}, 1);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic launch(input logic dir, input logic [4:0] amt, input logic [31:0] din);
        DIR   = dir;
        AMT   = amt;
        DIN   = din;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        DIR   = 1'($urandom);
        AMT   = 5'($urandom);
        DIN   = $urandom;
    endtask

    // lat counts cycles from the accepting edge to the cycle with DONE high.
    task automatic wait_done(input bit inject, output int lat, output int lc,
                             output int rc, output int bc);
        lat = 1; lc = 0; rc = 0; bc = 0;
        while (!DONE && lat < 40) begin
            lc += int'(L_SHIFT);
            rc += int'(R_SHIFT);
            bc += int'(BUSY);
            if (inject && lat == 1) begin
                START = 1'b1;
                DIN   = 32'hFFFF_0000;
                AMT   = 5'd3;
                DIR   = 1'b1;
            end else if (inject && lat == 2) begin
                START = 1'b0;
            end
            @(negedge CLK);
            lat++;
        end
        check("done_seen", {31'b0, DONE}, 1);
    endtask

    task automatic run_check(input logic dir, input logic [4:0] amt,
                             input logic [31:0] din, input logic [31:0] exp, input bit inject);
        int lat, lc, rc, bc;
        launch(dir, amt, din);
        wait_done(inject, lat, lc, rc, bc);
        check("latency", lat, 1 + int'(amt[0]) + int'(amt[4:1]));
        check("dout", DOUT, exp);
        check("sel_dir_cycles", dir ? rc : lc, int'(amt[4:1]));
        check("sel_other_cycles", dir ? lc : rc, 0);
        check("busy_cycles", bc, int'(amt[0]) + int'(amt[4:1]));
        @(negedge CLK);
        check("done_pulse_end", {31'b0, DONE}, 0);
        check("dout_hold", DOUT, exp);
    endtask

    typedef struct {
        logic        dir;
        logic [4:0]  amt;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int lat, lc, rc, bc, dones;
        logic        rdir;
        logic [4:0]  ramt;
        logic [31:0] rdin, rexp;

        vecs[0] = '{1'b0, 5'd5,  32'h0000_0001, 32'h0000_0020};
        vecs[1] = '{1'b1, 5'd31, 32'h8000_0000, 32'h0000_0001};
        vecs[2] = '{1'b0, 5'd0,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 5'd4,  32'hFFFF_FFFF, 32'hFFFF_FFF0};
        vecs[4] = '{1'b1, 5'd4,  32'hF0F0_F0F0, 32'h0F0F_0F0F};
        vecs[5] = '{1'b0, 5'd8,  32'h1234_5678, 32'h3456_7800};
        vecs[6] = '{1'b1, 5'd1,  32'h1234_5678, 32'h091A_2B3C};
        vecs[7] = '{1'b0, 5'd31, 32'h8000_0001, 32'h8000_0000};
        vecs[8] = '{1'b0, 5'd30, 32'h0000_0003, 32'hC000_0000};
        vecs[9] = '{1'b1, 5'd17, 32'hFFFF_FFFF, 32'h0000_7FFF};

        RST = 1'b1; START = 1'b0; DIR = 1'b0; AMT = 5'd0; DIN = 32'd0;
        @(negedge CLK);
        inv_en = 1;
        @(negedge CLK);
        check_reset_vals();
        RST = 1'b0;
        @(negedge CLK);

        for (int i = 0; i < 10; i++)
            run_check(vecs[i].dir, vecs[i].amt, vecs[i].din, vecs[i].exp, 1'b0);

        // START pulsed while busy must be ignored
        run_check(1'b0, 5'd5, 32'h0000_0001, 32'h0000_0020, 1'b1);

        // Back-to-back: second op accepted in the DONE cycle of the first
        launch(1'b0, 5'd0, 32'hDEAD_BEEF);
        wait_done(1'b0, lat, lc, rc, bc);
        check("b2b_lat0", lat, 1);
        check("b2b_dout0", DOUT, 32'hDEAD_BEEF);
        check("b2b_no_shift", {31'b0, NO_SHIFT}, 1);
        launch(1'b0, 5'd4, 32'hFFFF_FFFF);
        wait_done(1'b0, lat, lc, rc, bc);
        check("b2b_lat1", lat, 3);
        check("b2b_dout1", DOUT, 32'hFFFF_FFF0);
        check("b2b_lcnt", lc, 2);
        @(negedge CLK);

        // Reset in the middle of a long op
        launch(1'b1, 5'd31, 32'h8000_0000);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_reset_vals();
        dones = 0;
        repeat (20) begin
            dones += int'(DONE);
            @(negedge CLK);
        end
        check("no_done_after_rst", dones, 0);
        check("idle_after_rst", {31'b0, BUSY}, 0);
        run_check(1'b1, 5'd31, 32'h8000_0000, 32'h0000_0001, 1'b0);

        // Random ops against a reference shift
        for (int n = 0; n < 1000; n++) begin
            rdir = 1'($urandom);
            ramt = 5'($urandom);
            rdin = $urandom;
            rexp = rdir ? (rdin >> ramt) : (rdin << ramt);
            run_check(rdir, ramt, rdin, rexp, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
